neuron_accum_ctrl: RTL and testbench
====================================

# neuron_accum_ctrl

Sequencer on the driving side of the neuron's registered accumulate adder. It accepts a stream of signed 8-bit weighted terms and feeds each one, together with the running accumulator, into the adder's in1/in2 ports. It captures the adder's sum/carry one cycle later, saturates the result on signed overflow, and presents the finished neuron pre-activation (optionally ReLU'd) on a valid/ready output after N_TERMS terms.

## Interface
- N_TERMS, default 4: terms accumulated per neuron output; must be ≥1.
- RELU, default 0: 1 = clamp negative results to 0 at the output.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  term available.
- in_ready  out  1  block accepts a term this cycle.
- in_data  in  8 signed  weighted term.
- add_in1  out  16 signed  to adder in1; always the accumulator register.
- add_in2  out  8 signed  to adder in2; in_data on an accepted handshake, else 0.
- add_sum  in  16 signed  adder sum, registered in adder, valid 1 cycle after drive.
- add_carry  in  1  adder bit 16 (sign of the true 17-bit sum).
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts result.
- out_data  out  16 signed  accumulated (saturated, optionally ReLU'd) result.
- out_sat  out  1  sticky: any saturation occurred during this result.

## Operation
- FSM states: ACCEPT, WAIT, OUTPUT. Reset state is ACCEPT.
- ACCEPT: in_ready=1. On in_valid&in_ready, drive add_in2=in_data and go to WAIT.
- WAIT: in_ready=0. Overflow is detected when add_carry != add_sum[15].
  - On overflow: acc <= add_carry ? -32768 : 32767 and sat <= 1.
  - Otherwise: acc <= add_sum.
  - Then cnt++. If the new cnt == N_TERMS, go to OUTPUT, else go to ACCEPT.
- OUTPUT: out_valid=1 and in_ready=0.
  - out_data = (RELU && acc<0) ? 0 : acc; out_sat = sat.
  - On out_valid&out_ready: acc<=0, sat<=0, cnt<=0, go to ACCEPT.
- Saturation clamps acc; later terms add to the clamped value and may un-saturate it. sat stays sticky.
- cnt width is $clog2(N_TERMS+1).
- Reset values: acc=0, sat=0, cnt=0, out_valid=0, out_data=0, out_sat=0. in_ready=1 immediately after reset.
- Reset mid-operation discards the partial sum. The adder shares rst_n, so no stale add_sum is captured.
- in_data is sampled only on a handshake. in_valid may toggle freely; bubbles add latency only.

## Timing
- in_ready, out_valid and add_in2 are combinational from state and inputs. acc, sat, cnt and state are registered.
- Throughput is 1 term per 2 cycles. The add latency (1 cycle) is fixed by the adder.
- With in_valid held high and first handshake in cycle 0:
  - term k is accepted in cycle 2k;
  - out_valid rises in cycle 2·N_TERMS (cycle 8 for N_TERMS=4).
- After the output handshake in cycle t, in_ready=1 in cycle t+1.
- No in/out handshake overlap: in_ready=0 whenever out_valid=1.

## Structure
- neuron_pkg holds:
  - ACC_W=16 and IN_W=8;
  - ACC_MAX=16'sh7FFF and ACC_MIN=16'sh8000;
  - state enum typedef (ACCEPT, WAIT, OUTPUT);
  - a saturate(sum, carry) function.
- No sub-module. The adder is instantiated beside this block in the parent and wired add_in1→in1, add_in2→in2, sum→add_sum, carry→add_carry.
- The bench instantiates both.

## Test plan
- Basic sum: N_TERMS=4, terms 10,-3,7,1 with in_valid constant → out_data=15, out_sat=0, out_valid first high in cycle 8.
- Positive saturation: N_TERMS=300, all terms 127 → overflow on term 259 → out_data=32767, out_sat=1.
- Negative saturation: N_TERMS=300, all terms -128 → out_data=-32768, out_sat=1.
- Backpressure: hold out_ready=0 for 5 cycles in OUTPUT → out_valid, out_data, out_sat stable and in_ready=0 throughout. Then out_ready=1 → in_ready=1 next cycle, and the next result starts from acc=0.
- Bubbles: terms 5,5,5,5 with in_valid low 3 cycles between each → out_data=20, add_in2=0 in every non-handshake cycle.
- Reset and ReLU:
  - Assert rst_n=0 after 2 of 4 terms → all outputs at reset values, in_ready=1. Then terms 1,2,3,4 → out_data=10.
  - RELU=1 with terms -50,10,0,0 → out_data=0, out_sat=0.

Source files
------------

// File: rtl/neuron_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : neuron_pkg
// Purpose  : Shared widths, saturation limits, the accumulate-sequencer state
//            encoding and the saturating-resolve helper for the neuron
//            accumulate path.
// Contents : ACC_W / IN_W      accumulator and term widths
//            ACC_MAX / ACC_MIN signed accumulator clamp limits
//            state_t           ACCEPT / WAIT / OUTPUT encoding
//            saturate()        resolves a registered adder sum + carry
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package neuron_pkg;

   localparam int ACC_W = 16;
   localparam int IN_W  = 8;

   localparam logic signed [ACC_W-1:0] ACC_MAX = 16'sh7FFF;
   localparam logic signed [ACC_W-1:0] ACC_MIN = 16'sh8000;

   // Explicit 2-bit encoding so the state register width is fixed and stable
   // across tool versions.
   typedef enum logic [1:0] {
      ACCEPT = 2'd0,
      WAIT   = 2'd1,
      OUTPUT = 2'd2
   } state_t;

   // The adder's carry is bit 16 of the true sum, i.e. its real sign. When it
   // disagrees with bit 15 the 16-bit sum has wrapped; clamp toward the real
   // sign instead.
   function automatic logic signed [ACC_W-1:0] saturate(
      input logic signed [ACC_W-1:0] sum,
      input logic                    carry
   );
      logic signed [ACC_W-1:0] res;
      res = sum;
      if (carry != sum[ACC_W-1]) begin
         res = carry ? ACC_MIN : ACC_MAX;
      end
      return res;
   endfunction

endpackage : neuron_pkg
`default_nettype wire

// File: rtl/neuron_accum_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : neuron_accum_ctrl
// Purpose  : Drives the neuron's registered accumulate adder. Each accepted
//            signed term is presented to the adder together with the running
//            accumulator; the registered sum is captured one cycle later,
//            clamped on signed overflow, and after N_TERMS terms the finished
//            pre-activation (optionally ReLU'd) is offered downstream.
// Params   : N_TERMS  terms per output (>= 1)
//            RELU     1 = negative results are presented as 0
// Ports    : clk, rst_n            clock, async active-low reset
//            in_valid/in_ready     term handshake
//            in_data   [7:0]  s    weighted term
//            add_in1   [15:0] s    adder in1 (accumulator register)
//            add_in2   [7:0]  s    adder in2 (term on handshake, else 0)
//            add_sum   [15:0] s    registered adder sum
//            add_carry             registered adder bit 16
//            out_valid/out_ready   result handshake
//            out_data  [15:0] s    saturated (and optionally ReLU'd) result
//            out_sat               saturation seen during this result
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module neuron_accum_ctrl
   import neuron_pkg::*;
#(
   parameter int N_TERMS = 4,
   parameter bit RELU    = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [IN_W-1:0]  in_data,
   output logic signed [ACC_W-1:0] add_in1,
   output logic signed [IN_W-1:0]  add_in2,
   input  logic signed [ACC_W-1:0] add_sum,
   input  logic                    add_carry,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [ACC_W-1:0] out_data,
   output logic                    out_sat
);

   // Wide enough to hold the value N_TERMS itself.
   localparam int               CNT_W      = $clog2(N_TERMS + 1);
   localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(N_TERMS);

   state_t                  r_state;
   logic signed [ACC_W-1:0] r_acc;
   logic                    r_sat;
   logic [CNT_W-1:0]        r_cnt;

   logic                    w_in_hs;
   logic                    w_out_hs;
   logic                    w_ovf;
   logic [CNT_W-1:0]        w_cnt_next;

   assign w_in_hs    = (r_state == ACCEPT) && in_valid;
   assign w_out_hs   = (r_state == OUTPUT) && out_ready;
   assign w_ovf      = (add_carry != add_sum[ACC_W-1]);
   assign w_cnt_next = r_cnt + 1'b1;

   //---------------------------------------------------------------------------
   // Sequencer. The adder registers its result on the same edge that moves us
   // from ACCEPT to WAIT, so add_sum/add_carry are valid throughout WAIT and
   // are folded into the accumulator on the WAIT->next edge.
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ACCEPT;
         r_acc   <= '0;
         r_sat   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            ACCEPT: begin
               if (w_in_hs) begin
                  r_state <= WAIT;
               end
            end
            WAIT: begin
               // A clamped accumulator keeps accumulating, so later terms can
               // bring it back in range; the flag stays set regardless.
               r_acc <= saturate(add_sum, add_carry);
               if (w_ovf) begin
                  r_sat <= 1'b1;
               end
               r_cnt   <= w_cnt_next;
               r_state <= (w_cnt_next == c_cnt_last) ? OUTPUT : ACCEPT;
            end
            OUTPUT: begin
               if (w_out_hs) begin
                  r_acc   <= '0;
                  r_sat   <= 1'b0;
                  r_cnt   <= '0;
                  r_state <= ACCEPT;
               end
            end
            default: begin
               r_state <= ACCEPT;
            end
         endcase
      end
   end

   //---------------------------------------------------------------------------
   // Combinational outputs. in_ready and out_valid are mutually exclusive by
   // construction since they decode different states.
   //---------------------------------------------------------------------------
   assign in_ready  = (r_state == ACCEPT);
   assign out_valid = (r_state == OUTPUT);

   assign add_in1   = r_acc;
   // Zero outside a handshake so a free-running adder sees no stray term.
   assign add_in2   = w_in_hs ? in_data : '0;

   // Result bus is held at 0 outside OUTPUT so it shows reset values whenever
   // no result is being offered.
   always_comb begin
      out_data = '0;
      out_sat  = 1'b0;
      if (r_state == OUTPUT) begin
         out_sat  = r_sat;
         out_data = (RELU && r_acc[ACC_W-1]) ? '0 : r_acc;
      end
   end

endmodule : neuron_accum_ctrl
`default_nettype wire

// File: tb/tb_neuron_accum_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_neuron_accum_ctrl
// Purpose  : Self-checking bench for neuron_accum_ctrl. Three instances share
//            one stimulus stream: [0] N_TERMS=4, [1] N_TERMS=300, [2] N_TERMS=4
//            with RELU. Each instance has its own registered adder model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_neuron_accum_ctrl;

   logic              clk;
   logic              rst_n;
   logic              in_valid;
   logic signed [7:0] in_data;
   logic              out_ready;

   logic               in_ready  [3];
   logic signed [15:0] add_in1   [3];
   logic signed [7:0]  add_in2   [3];
   logic signed [15:0] add_sum   [3];
   logic               add_carry [3];
   logic               out_valid [3];
   logic signed [15:0] out_data  [3];
   logic               out_sat   [3];

   int checks = 0;
   int errors = 0;
   int mon_sel = 0;

   typedef struct {
      logic signed [15:0] d;
      logic               s;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      int                 sel;
      logic signed [7:0]  t [4];
      logic signed [15:0] d;
      logic               s;
   } vec_t;
   vec_t vecs[8];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      localparam int NT = (gi == 1) ? 300 : 4;
      localparam bit RL = (gi == 2);
      logic [16:0] r_add;

      neuron_accum_ctrl #(.N_TERMS(NT), .RELU(RL)) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (in_valid),
         .in_ready  (in_ready[gi]),
         .in_data   (in_data),
         .add_in1   (add_in1[gi]),
         .add_in2   (add_in2[gi]),
         .add_sum   (add_sum[gi]),
         .add_carry (add_carry[gi]),
         .out_valid (out_valid[gi]),
         .out_ready (out_ready),
         .out_data  (out_data[gi]),
         .out_sat   (out_sat[gi])
      );

      // Registered 17-bit adder sharing rst_n with the controller.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) r_add <= '0;
         else        r_add <= {add_in1[gi][15], add_in1[gi]} +
                              {{9{add_in2[gi][7]}}, add_in2[gi]};
      end
      assign add_sum[gi]   = r_add[15:0];
      assign add_carry[gi] = r_add[16];
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input int sel, input int a, input int b,
                               input int c, input int d, input int ed, input int es);
      vec_t v;
      v.sel  = sel;
      v.t[0] = 8'(a);
      v.t[1] = 8'(b);
      v.t[2] = 8'(c);
      v.t[3] = 8'(d);
      v.d    = 16'(ed);
      v.s    = es[0];
      return v;
   endfunction

   task automatic push_exp(input int d, input int s);
      exp_t e;
      e.d = 16'(d);
      e.s = s[0];
      sb.push_back(e);
   endtask

   // Per-cycle invariants plus scoreboard pop on each output handshake.
   always @(negedge clk) begin
      if (rst_n) begin
         if (in_ready[mon_sel] && out_valid[mon_sel]) begin
            checks++; errors++;
            $display("FAIL hs_overlap: in_ready and out_valid both 1 at %0t", $time);
         end
         chk("add_in2", int'(add_in2[mon_sel]),
             (in_valid && in_ready[mon_sel]) ? int'(in_data) : 0);
         if (out_valid[mon_sel] && out_ready) begin
            if (sb.size() == 0) begin
               checks++; errors++;
               $display("FAIL sb_empty: unexpected result %0d at %0t",
                        out_data[mon_sel], $time);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("out_data", int'(out_data[mon_sel]), int'(e.d));
               chk("out_sat", int'(out_sat[mon_sel]), int'(e.s));
            end
         end
      end
   end

   // All stimulus tasks start and end at posedge+1.
   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic send_term(input int sel, input logic signed [7:0] d);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = d;
      forever begin
         @(negedge clk);
         if (in_ready[sel]) break;
         n++;
         if (n > 50) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready stuck 0 on dut %0d", sel);
            break;
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = 8'($urandom);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drain_left", sb.size(), 0);
      @(posedge clk); #1;
   endtask

   task automatic wait_out(input int sel);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid[sel] && n < 20);
      chk("wait_out_valid", int'(out_valid[sel]), 1);
   endtask

   task automatic chk_reset_vals(input int sel, input string tag);
      chk({tag, "_in_ready"},  int'(in_ready[sel]),  1);
      chk({tag, "_out_valid"}, int'(out_valid[sel]), 0);
      chk({tag, "_out_data"},  int'(out_data[sel]),  0);
      chk({tag, "_out_sat"},   int'(out_sat[sel]),   0);
      chk({tag, "_add_in1"},   int'(add_in1[sel]),   0);
   endtask

   // 300-term run on dut 1: n1 copies of t1, then t2 for the rest.
   task automatic run300(input int n1, input int t1, input int t2);
      int acc, sat, s, t;
      acc = 0;
      sat = 0;
      for (int i = 0; i < 300; i++) begin
         t = (i < n1) ? t1 : t2;
         s = acc + t;
         if (s > 32767)       begin s = 32767;  sat = 1; end
         else if (s < -32768) begin s = -32768; sat = 1; end
         acc = s;
      end
      do_reset();
      mon_sel = 1;
      push_exp(acc, sat);
      for (int i = 0; i < 300; i++) begin
         send_term(1, 8'((i < n1) ? t1 : t2));
      end
      drain();
   endtask

   initial begin
      logic signed [7:0] basic [4];
      basic[0] = 8'sd10; basic[1] = -8'sd3; basic[2] = 8'sd7; basic[3] = 8'sd1;

      vecs[0] = mk(0,   10,   -3,    7,    1,   15, 0);
      vecs[1] = mk(0, -100, -100,   50,   20, -130, 0);
      vecs[2] = mk(0,  127,  127,  127,  127,  508, 0);
      vecs[3] = mk(0, -128, -128, -128, -128, -512, 0);
      vecs[4] = mk(2,  -50,   10,    0,    0,    0, 0);
      vecs[5] = mk(2,   30,  -10,    5,   -1,   24, 0);
      vecs[6] = mk(2,   -1,   -1,   -1,   -1,    0, 0);
      vecs[7] = mk(2,  100,  100,  -20,    7,  187, 0);

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) chk_reset_vals(i, "por");
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Basic sum with in_valid held: term k in cycle 2k, result in cycle 8.
      do_reset();
      mon_sel = 0;
      push_exp(15, 0);
      in_valid = 1'b1;
      for (int c = 0; c <= 8; c++) begin
         if (c < 8 && c % 2 == 0) in_data = basic[c/2];
         @(negedge clk);
         chk("basic_out_valid", int'(out_valid[0]), (c == 8) ? 1 : 0);
         chk("basic_in_ready",  int'(in_ready[0]),  (c < 8 && c % 2 == 0) ? 1 : 0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      drain();

      // Table of four-term vectors.
      for (int v = 0; v < 8; v++) begin
         do_reset();
         mon_sel = vecs[v].sel;
         push_exp(int'(vecs[v].d), int'(vecs[v].s));
         for (int k = 0; k < 4; k++) send_term(vecs[v].sel, vecs[v].t[k]);
         drain();
      end

      // Backpressure: result must hold while out_ready is low.
      do_reset();
      mon_sel   = 0;
      out_ready = 1'b0;
      push_exp(50, 0);
      send_term(0, 8'sd30); send_term(0, 8'sd20);
      send_term(0, -8'sd5); send_term(0, 8'sd5);
      wait_out(0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_out_valid", int'(out_valid[0]), 1);
         chk("bp_out_data",  int'(out_data[0]),  50);
         chk("bp_out_sat",   int'(out_sat[0]),   0);
         chk("bp_in_ready",  int'(in_ready[0]),  0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_ready_after", int'(in_ready[0]), 1);
      @(posedge clk); #1;
      push_exp(4, 0);
      for (int k = 0; k < 4; k++) send_term(0, 8'sd1);
      drain();

      // Bubbles between terms.
      do_reset();
      mon_sel = 0;
      push_exp(20, 0);
      for (int k = 0; k < 4; k++) begin
         send_term(0, 8'sd5);
         repeat (3) begin @(posedge clk); #1; end
      end
      drain();

      // Reset in the middle of a result discards the partial sum.
      do_reset();
      mon_sel = 0;
      send_term(0, 8'sd60);
      send_term(0, 8'sd70);
      rst_n = 1'b0;
      @(negedge clk);
      chk_reset_vals(0, "mid_rst");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("mid_rst_ready", int'(in_ready[0]), 1);
      @(posedge clk); #1;
      push_exp(10, 0);
      for (int k = 1; k <= 4; k++) send_term(0, 8'(k));
      drain();

      // Saturation: positive, negative, and clamp followed by recovery.
      run300(300, 127, 0);
      run300(300, -128, 0);
      run300(270, 127, -128);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_neuron_accum_ctrl
`default_nettype wire
